// File: rtl/count_enable_gen_pkg.sv
// Shared constants for the counter enable generator.
// Debounce state codes and default timing values.
package count_enable_gen_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ARM_HI = 2'd1;
   localparam logic [1:0] HIGH   = 2'd2;
   localparam logic [1:0] ARM_LO = 2'd3;

   localparam int DEF_DIV        = 5;
   localparam int DEF_DEB_CYCLES = 4;

   // Width of a counter that must reach n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/count_enable_gen_btn_debounce.sv
// Button synchronizer and debounce state machine.
// Emits a one-cycle press pulse when a press is accepted.
module btn_debounce
   import count_enable_gen_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse
);

   localparam int CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          btn_s;
   logic [1:0]    state;
   logic [CW-1:0] deb_cnt;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         btn_s <= sync1;
      end
   end

   // Accept a level change only after it holds for DEB_CYCLES more samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         btn_level   <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state   <= ARM_HI;
                  deb_cnt <= '0;
               end
            end
            ARM_HI: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (deb_cnt == LAST) begin
                  state       <= HIGH;
                  btn_level   <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (!btn_s) begin
                  state   <= ARM_LO;
                  deb_cnt <= '0;
               end
            end
            ARM_LO: begin
               if (btn_s) begin
                  state <= HIGH;
               end else if (deb_cnt == LAST) begin
                  state     <= IDLE;
                  btn_level <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               btn_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/count_enable_gen.sv
// Enable strobe source for the 4-bit counter.
// Periodic prescaler tick in run mode, debounced press in step mode.
module count_enable_gen
   import count_enable_gen_pkg::*;
#(
   parameter int DIV        = DEF_DIV,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic mode,
   output logic en,
   output logic tick,
   output logic btn_level
);

   localparam int PW = cnt_width(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          press_pulse;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .press_pulse (press_pulse)
   );

   // Prescaler: wraps every DIV cycles in run mode, parked at zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (!mode) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   // Select the strobe source by the current mode; no added latency.
   always_comb begin
      en = mode ? tick : press_pulse;
   end

endmodule
